// File: rtl/port_arbiter_pkg.sv
// Shared widths, flit type codes and arbiter state encoding for the
// output-port switch allocator.
package port_arbiter_pkg;

    localparam int NINPORT = 5;   // input controllers per router
    localparam int PORTW   = 2;   // port field is PORTW+1 bits
    localparam int TYPEW   = 1;   // flit type field is TYPEW+1 bits

    localparam logic [TYPEW:0] TYPE_HEAD     = 2'd0;
    localparam logic [TYPEW:0] TYPE_DATA     = 2'd1;
    localparam logic [TYPEW:0] TYPE_TAIL     = 2'd2;
    localparam logic [TYPEW:0] TYPE_HEADTAIL = 2'd3;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Next round-robin start position after input idx, wrapping 4 -> 0.
    function automatic logic [2:0] rr_next(input logic [2:0] idx);
        return (idx >= 3'(NINPORT - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/port_arbiter_rr_pick.sv
// Five-way cyclic priority picker: returns the first set bit of hit,
// searching upward from ptr and wrapping past the last input.
module rr_pick
    import port_arbiter_pkg::*;
(
    input  logic [NINPORT-1:0] hit,
    input  logic [2:0]         ptr,
    output logic [NINPORT-1:0] grant,
    output logic [2:0]         idx,
    output logic               any
);

    // Walk the inputs starting at ptr and take the first hit.
    always_comb begin
        logic [3:0] cand;
        // NOTE: every output gets a default before the loop so no path
        // leaves one unassigned, which would otherwise infer a latch.
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 0; k < NINPORT; k++) begin
            cand = {1'b0, ptr} + 4'(k);
            if (cand >= 4'(NINPORT)) begin
                cand = cand - 4'(NINPORT);
            end
            if (!any && (cand < 4'(NINPORT)) && hit[cand[2:0]]) begin
                grant[cand[2:0]] = 1'b1;
                idx              = cand[2:0];
                any              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/port_arbiter.sv
// Switch allocator for one router output port: packet-granular
// round-robin among the five input controllers, locked head to tail.
module port_arbiter
    import port_arbiter_pkg::*;
#(
    parameter int ROUTERID = 0,
    parameter int PORTID   = 0
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               req_0,
    input  logic               req_1,
    input  logic               req_2,
    input  logic               req_3,
    input  logic               req_4,
    input  logic [PORTW:0]     port_0,
    input  logic [PORTW:0]     port_1,
    input  logic [PORTW:0]     port_2,
    input  logic [PORTW:0]     port_3,
    input  logic [PORTW:0]     port_4,
    input  logic               ivalid_0,
    input  logic               ivalid_1,
    input  logic               ivalid_2,
    input  logic               ivalid_3,
    input  logic               ivalid_4,
    input  logic [TYPEW:0]     itype_0,
    input  logic [TYPEW:0]     itype_1,
    input  logic [TYPEW:0]     itype_2,
    input  logic [TYPEW:0]     itype_3,
    input  logic [TYPEW:0]     itype_4,
    output logic               grt_0,
    output logic               grt_1,
    output logic               grt_2,
    output logic               grt_3,
    output logic               grt_4,
    output logic [NINPORT-1:0] sel,
    output logic               busy,
    output logic [2:0]         owner
);

    localparam logic [PORTW:0] MY_PORT = PORTID[PORTW:0];

    logic [NINPORT-1:0] req_v;
    logic [NINPORT-1:0] ivalid_v;
    logic [PORTW:0]     port_v  [NINPORT];
    logic [TYPEW:0]     itype_v [NINPORT];
    logic [NINPORT-1:0] hit;
    logic [NINPORT-1:0] pick_grant;
    logic [2:0]         pick_idx;
    logic               pick_any;
    logic [NINPORT-1:0] grt;
    logic               illegal;

    arb_state_e state_q, state_d;
    logic [2:0] owner_q, owner_d;
    logic [2:0] rr_q, rr_d;

    assign req_v    = {req_4, req_3, req_2, req_1, req_0};
    assign ivalid_v = {ivalid_4, ivalid_3, ivalid_2, ivalid_1, ivalid_0};
    assign port_v   = '{port_0, port_1, port_2, port_3, port_4};
    assign itype_v  = '{itype_0, itype_1, itype_2, itype_3, itype_4};

    // Requests aimed at the output port this arbiter owns.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NINPORT; i++) begin
            hit[i] = req_v[i] && (port_v[i] == MY_PORT);
        end
    end

    rr_pick u_pick (
        .hit   (hit),
        .ptr   (rr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Grants and next state: pick a new packet while idle, follow the owner while busy.
    always_comb begin
        grt     = '0;
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        illegal = 1'b0;
        if (rst_) begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_any) begin
                        grt = pick_grant;
                        if (ivalid_v[pick_idx]) begin
                            case (itype_v[pick_idx])
                                TYPE_HEAD: begin
                                    state_d = ARB_BUSY;
                                    owner_d = pick_idx;
                                end
                                TYPE_HEADTAIL: rr_d = rr_next(pick_idx);
                                default:       illegal = 1'b1;
                            endcase
                        end
                    end
                end
                ARB_BUSY: begin
                    if (hit[owner_q]) begin
                        grt[owner_q] = 1'b1;
                        if (ivalid_v[owner_q]) begin
                            case (itype_v[owner_q])
                                TYPE_TAIL: begin
                                    state_d = ARB_IDLE;
                                    owner_d = '0;
                                    rr_d    = rr_next(owner_q);
                                end
                                TYPE_DATA: ;
                                default:   illegal = 1'b1;
                            endcase
                        end
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    // State, owner and round-robin pointer; reset drops any lock at once.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so each register samples pre-edge values.
        if (!rst_) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

    // Flag granted flits whose type does not fit the current state; they change nothing.
    always_ff @(posedge clk) begin
        if (rst_) begin
            assert (!illegal)
                else $error("port_arbiter R%0d P%0d: illegal flit type for arbiter state",
                            ROUTERID, PORTID);
        end
    end

    assign {grt_4, grt_3, grt_2, grt_1, grt_0} = grt;
    assign sel   = grt;
    assign busy  = (state_q == ARB_BUSY);
    assign owner = owner_q;

endmodule

// File: doc/port_arbiter.md
# port_arbiter

Output-port switch allocator for one physical output of the router. It arbitrates among the five input controllers' `req`/`port` requests and returns the per-input `grt_*` strobes. Grants are round-robin at packet granularity, and the output stays locked to one input from head flit to tail flit. The router instantiates one `port_arbiter` per output port, next to the crossbar.

## Interface
Parameters:
- `ROUTERID`, default 0: router identifier, used for debug only.
- `PORTID`, default 0: index of the output port this arbiter owns (0..4). It is compared against the requested `port_i`.

Ports:
- `clk` input, 1 bit: clock.
- `rst_` input, 1 bit: synchronous, active-low reset. There is one clock; reset is synchronous and active-low.
- `req_0`..`req_4` input, 1 bit each: request from input controller *i*.
- `port_0`..`port_4` input, `` `PORTW ``+1 bits each: output port requested by input *i*. Valid only while `req_i` = 1.
- `ivalid_0`..`ivalid_4` input, 1 bit each: input *i* is transferring a flit this cycle (its `ovalid`).
- `itype_0`..`itype_4` input, `` `TYPEW ``+1 bits each: flit type of that transfer, taken from `` odata[`TYPE_MSB:`TYPE_LSB] ``.
- `grt_0`..`grt_4` output, 1 bit each: grant to input *i*. At most one is high.
- `sel` output, 5 bits: one-hot crossbar select. It equals `{grt_4..grt_0}`.
- `busy` output, 1 bit: the output is locked to a packet in flight.
- `owner` output, 3 bits: index of the locked input. It is 0 when not busy.

## Operation
- A request counts as a hit for input *i* when `req_i` && (`port_i` == `PORTID`).
- State machine with two states, `IDLE` and `BUSY`. Registered state:
  - `state`
  - `owner` (3 bits)
  - `rr_ptr` (3 bits, range 0..4)
- **IDLE**
  - Grant the first hit, searching cyclically from `rr_ptr` upward through 4 and wrapping to 0.
  - No hits: no grant, and all state is held.
  - If the granted input has `ivalid_i` with type `` `TYPE_HEAD ``: go to `BUSY` and set `owner` = *i*.
  - If the type is `` `TYPE_HEADTAIL ``: stay in `IDLE` and set `rr_ptr` = (*i*+1) mod 5.
  - Granted but no `ivalid_i`: nothing is committed, and arbitration is re-evaluated next cycle.
- **BUSY**
  - `grt_owner` = hit(`owner`). All other grants are 0, regardless of their requests.
  - The owner dropping `req` (empty buffer, or downstream not ready) holds the lock with no grant. There is no timeout.
  - Owner transfer with type `` `TYPE_TAIL ``: go to `IDLE` and set `rr_ptr` = (`owner`+1) mod 5.
  - `` `TYPE_DATA `` transfers keep the `BUSY` state.
- The `ivalid`/`itype` of non-granted inputs are ignored.
- A granted transfer whose type is illegal for the state (for example HEAD while `BUSY`, or DATA/TAIL while `IDLE`): no state change. A simulation-only `$display` error tags it with `ROUTERID`/`PORTID`.
- Wrap-around: `rr_ptr` of 4 advances to 0. The search order from `rr_ptr` = 3 is 3, 4, 0, 1, 2.

## Timing
- Grants are combinational from the current-cycle `req_*`/`port_*` and the registered state, so input *i* may transfer in the same cycle its `grt_i` rises.
- `state`, `owner` and `rr_ptr` update on the `clk` rising edge following the transfer.
- A new packet can be granted in the cycle immediately after a TAIL or HEADTAIL transfer, so there are no bubble cycles.
- Reset values, applied on a `clk` edge with `rst_` = 0:
  - `state` = `IDLE`, `owner` = 0, `rr_ptr` = 0, `busy` = 0.
  - All `grt_*` = 0 while `rst_` is low, including the combinational path.
- Reset mid-packet abandons the lock immediately. The arbiter does not wait for the tail.
- Simultaneous hits are resolved only by `rr_ptr` order. No input gets priority when it ties with `rr_ptr`.

## Structure
- Flit type codes and the `` `PORTW ``/`` `TYPEW `` widths come from `define.v`. Add `` `ARB_IDLE ``/`` `ARB_BUSY `` state codes and `` `NINPORT `` (5) there.
- Sub-module `rr_pick`: a purely combinational 5-way cyclic priority picker. It takes a hit vector and a pointer and returns a one-hot result plus an index. It is reusable by a future VC allocator.

## Test plan
- **Reset / idle:** hold `rst_` = 0 for 2 cycles with every `req` high → all `grt` = 0, `busy` = 0. After release, with `PORTID` = 2 and all inputs requesting port 2 → `grt_0` = 1.
- **Round-robin fairness:** inputs 0, 1 and 4 repeatedly send HEADTAIL to `PORTID` → the grant order is 0, 1, 4, 0, 1, 4, with one grant per cycle.
- **Packet lock:** input 3 sends HEAD, DATA, DATA, TAIL while input 1 requests continuously → `grt_1` stays 0 for 4 cycles. `busy` is 1 from the cycle after HEAD through the TAIL cycle. `grt_1` = 1 in cycle 5.
- **Owner stall:** input 2 sends HEAD, then drops `req` for 3 cycles while input 0 requests → no grant for those 3 cycles, and `owner` stays 2. TAIL releases the lock, and the next grant goes to input 0.
- **Port filter / wrap:** with `rr_ptr` = 4, inputs 1 and 4 request port ≠ `PORTID` and input 0 requests `PORTID` → `grt_0` = 1.
- **Reset mid-packet:** assert `rst_` = 0 during a DATA flit → the next cycle shows `busy` = 0, `owner` = 0, `rr_ptr` = 0.
